// File: rtl/enigma_history_buffer_pkg.sv
// Shared Enigma letter/ASCII constants, used by the history buffer and the
// keycode/LCD conversion blocks.
package enigma_history_buffer_pkg;

  localparam int LETTER_W = 5;

  typedef logic [LETTER_W-1:0] letter_t;

  localparam letter_t    LETTER_MAX  = 5'd25;
  localparam logic [7:0] ASCII_A     = 8'h41;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

endpackage

// File: rtl/enigma_history_buffer.sv
// Circular history of encrypted letters shown on the LCD page; position 0 is
// always the oldest visible character, unfilled positions read as blanks.
module enigma_history_buffer
  import enigma_history_buffer_pkg::*;
#(
  parameter int         ADDR_W     = 5,
  parameter logic [7:0] BLANK_CHAR = ASCII_SPACE
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [4:0]        wr_letter,
  input  logic              clear,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata,
  output logic [ADDR_W:0]   count,
  output logic              wrapped
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

  letter_t mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              wrapped_q, wrapped_d;
  logic [7:0]        rdata_q, rdata_d;

  logic              accept;
  logic              mem_we;
  logic              full;
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_idx;

  always_comb begin
    accept    = wr_en && !clear && (wr_letter <= LETTER_MAX);
    mem_we    = accept && reset_n;
    full      = (count_q == FULL_COUNT);
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    wrapped_d = wrapped_q;

    if (clear) begin
      wr_ptr_d  = '0;
      count_d   = '0;
      wrapped_d = 1'b0;
    end else if (accept) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (full) begin
        wrapped_d = 1'b1;
      end else begin
        count_d = count_q + (ADDR_W+1)'(1);
      end
    end
  end

  // Once full, the oldest entry sits at the write pointer, so rotate by it.
  always_comb begin
    rd_idx   = full ? (wr_ptr_q + raddr) : raddr;
    rd_valid = full || ({1'b0, raddr} < count_q);
    rdata_d  = rd_valid ? (ASCII_A + {{(8-LETTER_W){1'b0}}, mem[rd_idx]})
                        : BLANK_CHAR;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      count_q   <= '0;
      wrapped_q <= 1'b0;
      rdata_q   <= BLANK_CHAR;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      wrapped_q <= wrapped_d;
      rdata_q   <= rdata_d;
    end
  end

  // No reset on the array so it maps onto distributed RAM; count masks stale data.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= wr_letter;
    end
  end

  assign rdata   = rdata_q;
  assign count   = count_q;
  assign wrapped = wrapped_q;

endmodule

// File: tb/tb_enigma_history_buffer.sv
// Scoreboard bench for enigma_history_buffer: reads push hand-computed
// characters into a queue that a monitor pops one cycle after issue.
module tb_enigma_history_buffer;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } sb_entry_t;

  logic       clk;
  logic       reset_n;
  logic       wr_en;
  logic [4:0] wr_letter;
  logic       clear;
  logic [4:0] raddr;
  logic [7:0] rdata;
  logic [5:0] count;
  logic       wrapped;

  logic       rd_req;
  logic       rd_fire;
  sb_entry_t  sb[$];
  int         checks;
  int         errors;

  enigma_history_buffer #(
    .ADDR_W    (5),
    .BLANK_CHAR(8'h20)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_letter(wr_letter),
    .clear    (clear),
    .raddr    (raddr),
    .rdata    (rdata),
    .count    (count),
    .wrapped  (wrapped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mirrors the one-cycle read latency so the monitor knows when rdata is due.
  always @(posedge clk) rd_fire <= rd_req;

  task automatic checkOutput(input string nm, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", nm, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (rd_fire) begin
      if (sb.size() == 0) begin
        checkOutput("scoreboard_underflow", 1, 0);
      end else begin
        sb_entry_t e;
        e = sb.pop_front();
        checkOutput(e.name, int'(rdata), int'(e.exp));
      end
    end
  end

  task automatic applyStimulus(input logic we, input logic [4:0] letter,
                               input logic clr, input logic rn,
                               input logic [4:0] ra, input logic rq,
                               input logic [7:0] exp, input string nm);
    @(negedge clk);
    wr_en     = we;
    wr_letter = letter;
    clear     = clr;
    reset_n   = rn;
    raddr     = ra;
    rd_req    = rq;
    if (rq) sb.push_back('{nm, exp});
  endtask

  task automatic writeLetter(input logic [4:0] letter);
    applyStimulus(1'b1, letter, 1'b0, 1'b1, 5'd0, 1'b0, 8'h00, "");
  endtask

  task automatic readPos(input logic [4:0] ra, input logic [7:0] exp, input string nm);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, ra, 1'b1, exp, nm);
  endtask

  task automatic doClear();
    applyStimulus(1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 8'h00, "");
  endtask

  task automatic checkCounters(input int exp_count, input logic exp_wrapped, input string nm);
    @(negedge clk);
    wr_en  = 1'b0;
    clear  = 1'b0;
    rd_req = 1'b0;
    checkOutput({nm, "_count"}, int'(count), exp_count);
    checkOutput({nm, "_wrapped"}, int'(wrapped), int'(exp_wrapped));
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset_n   = 1'b0;
    wr_en     = 1'b0;
    wr_letter = 5'd0;
    clear     = 1'b0;
    raddr     = 5'd0;
    rd_req    = 1'b0;

    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 8'h00, "");
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 8'h00, "");
    checkCounters(0, 1'b0, "reset");
    checkOutput("reset_rdata", int'(rdata), 'h20);
    for (int i = 0; i < 32; i++) readPos(5'(i), 8'h20, "blank_after_reset");

    writeLetter(5'd7);
    writeLetter(5'd4);
    writeLetter(5'd11);
    writeLetter(5'd11);
    writeLetter(5'd14);
    checkCounters(5, 1'b0, "hello");
    readPos(5'd0, 8'h48, "hello_0");
    readPos(5'd1, 8'h45, "hello_1");
    readPos(5'd2, 8'h4C, "hello_2");
    readPos(5'd3, 8'h4C, "hello_3");
    readPos(5'd4, 8'h4F, "hello_4");
    readPos(5'd5, 8'h20, "hello_5_blank");

    doClear();
    writeLetter(5'd1);
    writeLetter(5'd2);
    writeLetter(5'd3);
    writeLetter(5'd27);
    checkCounters(3, 1'b0, "bad_letter");
    readPos(5'd0, 8'h42, "bad_letter_0");
    readPos(5'd1, 8'h43, "bad_letter_1");
    readPos(5'd2, 8'h44, "bad_letter_2");
    readPos(5'd3, 8'h20, "bad_letter_3_blank");
    writeLetter(5'd4);
    readPos(5'd3, 8'h45, "after_bad_letter_3");

    doClear();
    for (int i = 0; i <= 32; i++) writeLetter(5'(i % 26));
    checkCounters(32, 1'b1, "wrap33");
    readPos(5'd0, 8'h42, "wrap33_oldest");
    readPos(5'd30, 8'h46, "wrap33_30");
    readPos(5'd31, 8'h47, "wrap33_newest");

    doClear();
    for (int i = 0; i < 10; i++) writeLetter(5'(i));
    checkCounters(10, 1'b0, "ten");
    applyStimulus(1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 8'h00, "");
    checkCounters(0, 1'b0, "clear_wins");
    readPos(5'd0, 8'h20, "clear_wins_blank");
    writeLetter(5'd25);
    readPos(5'd0, 8'h5A, "after_clear_z");

    applyStimulus(1'b1, 5'd2, 1'b0, 1'b1, 5'd1, 1'b1, 8'h20, "same_edge_pre_write");
    readPos(5'd1, 8'h43, "next_edge_post_write");
    checkCounters(2, 1'b0, "same_edge");

    doClear();
    for (int i = 0; i < 32; i++) writeLetter(5'(i % 26));
    checkCounters(32, 1'b0, "exact_full");
    readPos(5'd0, 8'h41, "exact_full_0");
    readPos(5'd31, 8'h46, "exact_full_31");
    applyStimulus(1'b1, 5'd9, 1'b0, 1'b0, 5'd0, 1'b1, 8'h20, "reset_rdata_blank");
    checkCounters(0, 1'b0, "reset_full");
    readPos(5'd0, 8'h20, "reset_full_blank");
    writeLetter(5'd10);
    readPos(5'd0, 8'h4B, "post_reset_first");
    checkCounters(1, 1'b0, "post_reset");

    @(negedge clk);
    @(negedge clk);
    checkOutput("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
